// File: rtl/gbf_flgwei_rdctrl.sv
// Read-side sequencer for the GBF flag/weight region: streams one feature group's
// words from the GBF SRAM read port onto a valid/ready channel toward the PE array.
module gbf_flgwei_rdctrl #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 20,
  parameter int GRP_WIDTH  = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            Reset_FtrLay,
  input  logic                            Reset_FtrGrp,
  input  logic                            Next_FtrGrp,
  input  logic                            GrpTab_EnWr,
  input  logic [GRP_WIDTH-1:0]            GrpTab_AddrWr,
  input  logic [ADDR_WIDTH+LEN_WIDTH-1:0] GrpTab_DatWr,
  output logic                            GBF_EnRd,
  output logic [ADDR_WIDTH-1:0]           GBF_AddrRd,
  input  logic [DATA_WIDTH-1:0]           GBF_DatRd,
  output logic                            Dat_Val,
  input  logic                            Dat_Rdy,
  output logic [DATA_WIDTH-1:0]           Dat_Out,
  output logic [GRP_WIDTH-1:0]            CntFtrGrp,
  output logic                            Grp_Done,
  output logic                            Busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STRM = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int TAB_DEPTH = 1 << GRP_WIDTH;

  logic [1:0]            state_q, state_d;
  logic [GRP_WIDTH-1:0]  grp_q, grp_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic                  zdone_q, zdone_d;
  logic [1:0]            fcnt_q, fcnt_d;
  logic                  wptr_q, wptr_d;
  logic                  rptr_q, rptr_d;

  logic [DATA_WIDTH-1:0]           fifo_q [2];
  logic [ADDR_WIDTH+LEN_WIDTH-1:0] tab_q [TAB_DEPTH];

  logic                            cmd;
  logic                            pop;
  logic                            push;
  logic                            issue;
  logic                            last_pop;
  logic [2:0]                      occ;
  logic [GRP_WIDTH-1:0]            new_grp;
  logic [ADDR_WIDTH+LEN_WIDTH-1:0] new_ent;

  always_comb begin
    cmd     = Reset_FtrLay | Reset_FtrGrp | Next_FtrGrp;
    new_grp = grp_q;
    if (Reset_FtrLay)
      new_grp = '0;
    else if (Next_FtrGrp && !Reset_FtrGrp)
      new_grp = grp_q + GRP_WIDTH'(1);
    // Table read sees the pre-write contents when a write hits the same entry.
    new_ent = tab_q[new_grp];

    push  = inflight_q;
    pop   = (fcnt_q != 2'd0) && Dat_Rdy;
    occ   = 3'(fcnt_q) + 3'(inflight_q) - 3'(pop);
    issue = (state_q == ST_STRM) && (rem_q != '0) && (occ < 3'd2);
    last_pop = (state_q == ST_STRM) && (rem_q == '0) && !inflight_q &&
               pop && (fcnt_q == 2'd1);

    state_d    = state_q;
    grp_d      = grp_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    inflight_d = issue;
    zdone_d    = 1'b0;
    wptr_d     = push ? ~wptr_q : wptr_q;
    rptr_d     = pop ? ~rptr_q : rptr_q;
    fcnt_d     = fcnt_q + 2'(push) - 2'(pop);

    if (issue) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      rem_d  = rem_q - LEN_WIDTH'(1);
    end
    if (last_pop)
      state_d = ST_DONE;

    // A command restarts everything; a read still in flight becomes a discard.
    if (cmd) begin
      grp_d      = new_grp;
      addr_d     = new_ent[ADDR_WIDTH+LEN_WIDTH-1:LEN_WIDTH];
      rem_d      = new_ent[LEN_WIDTH-1:0];
      inflight_d = 1'b0;
      fcnt_d     = 2'd0;
      wptr_d     = 1'b0;
      rptr_d     = 1'b0;
      zdone_d    = (new_ent[LEN_WIDTH-1:0] == '0);
      state_d    = (new_ent[LEN_WIDTH-1:0] == '0) ? ST_DONE : ST_STRM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grp_q      <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      zdone_q    <= 1'b0;
      fcnt_q     <= 2'd0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      zdone_q    <= zdone_d;
      fcnt_q     <= fcnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (GrpTab_EnWr)
      tab_q[GrpTab_AddrWr] <= GrpTab_DatWr;
    if (push)
      fifo_q[wptr_q] <= GBF_DatRd;
  end

  assign GBF_EnRd   = issue;
  assign GBF_AddrRd = addr_q;
  assign Dat_Val    = (fcnt_q != 2'd0);
  assign Dat_Out    = Dat_Val ? fifo_q[rptr_q] : '0;
  assign CntFtrGrp  = grp_q;
  assign Grp_Done   = last_pop | zdone_q;
  assign Busy       = (state_q == ST_STRM);

endmodule
